// File: rtl/uart_loopback_bist.sv
// Loopback self-test engine for a UART core with Tx tied to Rx.
// Sends NUM_WORDS words (incrementing or Galois LFSR pattern). Each word is
// received, its ready flag cleared, and the word compared against the sent value.
// Reports pass/fail, error count, first mismatch and receive timeout.
// Every output comes straight from a register.
module uart_loopback_bist #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       NUM_WORDS    = 3,
  parameter int unsigned       TIMEOUT_CYC  = 65536,
  parameter logic [DATA_W-1:0] LFSR_TAPS    = 8'hB8,
  parameter logic [DATA_W-1:0] LFSR_SEED    = 8'h01,
  parameter bit                STOP_ON_FAIL = 1'b1,
  localparam int unsigned      CW           = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              start,
  input  logic              pattern_sel,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  input  logic              rx_ready,
  output logic              rx_ready_clr,
  input  logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CW-1:0]     err_count,
  output logic [CW-1:0]     words_done,
  output logic [DATA_W-1:0] first_exp,
  output logic [DATA_W-1:0] first_got
);

  localparam int unsigned       TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]     TMO_ONE    = TW'(1);
  localparam logic [CW-1:0]     WORDS_LAST = CW'(NUM_WORDS);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]     ERR_MAX    = {CW{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ONE   = DATA_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_RX = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Next word of the selected pattern: increment with wrap, or Galois LFSR shift.
  function automatic logic [DATA_W-1:0] advance_pattern(input logic [DATA_W-1:0] p,
                                                        input logic lfsr);
    logic [DATA_W-1:0] r;
    if (lfsr) begin
      r = p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
    end else begin
      r = p + DATA_ONE;
    end
    return r;
  endfunction

  state_t            state_r, state_nx_s;
  logic [DATA_W-1:0] pattern_r, pattern_nx_s;
  logic              lfsr_mode_r, lfsr_mode_nx_s;
  logic [TW-1:0]     tmo_cnt_r, tmo_cnt_nx_s;
  logic [DATA_W-1:0] rx_cap_r, rx_cap_nx_s;
  logic              tx_wr_en_r, tx_wr_en_nx_s;
  logic              rx_ready_clr_r, rx_ready_clr_nx_s;
  logic              busy_r, busy_nx_s;
  logic              done_r, done_nx_s;
  logic              pass_r, pass_nx_s;
  logic              timeout_r, timeout_nx_s;
  logic [CW-1:0]     err_count_r, err_count_nx_s;
  logic [CW-1:0]     words_done_r, words_done_nx_s;
  logic [DATA_W-1:0] first_exp_r, first_exp_nx_s;
  logic [DATA_W-1:0] first_got_r, first_got_nx_s;
  logic              mismatch_s;

  assign mismatch_s = (rx_cap_r != pattern_r);

  // Next-state and next-register values; everything defaults to hold.
  always_comb begin
    state_nx_s        = state_r;
    pattern_nx_s      = pattern_r;
    lfsr_mode_nx_s    = lfsr_mode_r;
    tmo_cnt_nx_s      = tmo_cnt_r;
    rx_cap_nx_s       = rx_cap_r;
    tx_wr_en_nx_s     = 1'b0;
    rx_ready_clr_nx_s = 1'b0;
    done_nx_s         = done_r;
    pass_nx_s         = pass_r;
    timeout_nx_s      = timeout_r;
    err_count_nx_s    = err_count_r;
    words_done_nx_s   = words_done_r;
    first_exp_nx_s    = first_exp_r;
    first_got_nx_s    = first_got_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          done_nx_s       = 1'b0;
          pass_nx_s       = 1'b0;
          timeout_nx_s    = 1'b0;
          err_count_nx_s  = {CW{1'b0}};
          words_done_nx_s = {CW{1'b0}};
          first_exp_nx_s  = {DATA_W{1'b0}};
          first_got_nx_s  = {DATA_W{1'b0}};
          lfsr_mode_nx_s  = pattern_sel;
          pattern_nx_s    = pattern_sel ? LFSR_SEED : {DATA_W{1'b0}};
          state_nx_s      = ST_SEND;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_SEND: begin
        // A ready still pending from the previous word must be gone first.
        if (!tx_busy && !rx_ready) begin
          tx_wr_en_nx_s = 1'b1;
          tmo_cnt_nx_s  = {TW{1'b0}};
          state_nx_s    = ST_WAIT_RX;
        end else begin
          state_nx_s = ST_SEND;
        end
      end
      ST_WAIT_RX: begin
        if (rx_ready) begin
          rx_cap_nx_s       = rx_data;
          rx_ready_clr_nx_s = 1'b1;
          state_nx_s        = ST_CLEAR;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_nx_s = 1'b1;
          done_nx_s    = 1'b1;
          pass_nx_s    = 1'b0;
          state_nx_s   = ST_DONE;
        end else begin
          tmo_cnt_nx_s = tmo_cnt_r + TMO_ONE;
        end
      end
      ST_CLEAR: begin
        state_nx_s = ST_CHECK;
      end
      ST_CHECK: begin
        words_done_nx_s = words_done_r + CNT_ONE;
        if (mismatch_s) begin
          err_count_nx_s = (err_count_r == ERR_MAX) ? ERR_MAX : (err_count_r + CNT_ONE);
          if (err_count_r == {CW{1'b0}}) begin
            first_exp_nx_s = pattern_r;
            first_got_nx_s = rx_cap_r;
          end else begin
            first_exp_nx_s = first_exp_r;
          end
        end else begin
          err_count_nx_s = err_count_r;
        end
        if ((mismatch_s && STOP_ON_FAIL) || (words_done_nx_s == WORDS_LAST)) begin
          done_nx_s  = 1'b1;
          pass_nx_s  = !mismatch_s && (err_count_r == {CW{1'b0}});
          state_nx_s = ST_DONE;
        end else begin
          pattern_nx_s = advance_pattern(pattern_r, lfsr_mode_r);
          state_nx_s   = ST_SEND;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    busy_nx_s = (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      pattern_r      <= {DATA_W{1'b0}};
      lfsr_mode_r    <= 1'b0;
      tmo_cnt_r      <= {TW{1'b0}};
      rx_cap_r       <= {DATA_W{1'b0}};
      tx_wr_en_r     <= 1'b0;
      rx_ready_clr_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      timeout_r      <= 1'b0;
      err_count_r    <= {CW{1'b0}};
      words_done_r   <= {CW{1'b0}};
      first_exp_r    <= {DATA_W{1'b0}};
      first_got_r    <= {DATA_W{1'b0}};
    end else begin
      state_r        <= state_nx_s;
      pattern_r      <= pattern_nx_s;
      lfsr_mode_r    <= lfsr_mode_nx_s;
      tmo_cnt_r      <= tmo_cnt_nx_s;
      rx_cap_r       <= rx_cap_nx_s;
      tx_wr_en_r     <= tx_wr_en_nx_s;
      rx_ready_clr_r <= rx_ready_clr_nx_s;
      busy_r         <= busy_nx_s;
      done_r         <= done_nx_s;
      pass_r         <= pass_nx_s;
      timeout_r      <= timeout_nx_s;
      err_count_r    <= err_count_nx_s;
      words_done_r   <= words_done_nx_s;
      first_exp_r    <= first_exp_nx_s;
      first_got_r    <= first_got_nx_s;
    end
  end

  assign tx_data      = pattern_r;
  assign tx_wr_en     = tx_wr_en_r;
  assign rx_ready_clr = rx_ready_clr_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign timeout      = timeout_r;
  assign err_count    = err_count_r;
  assign words_done   = words_done_r;
  assign first_exp    = first_exp_r;
  assign first_got    = first_got_r;

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Bench for uart_loopback_bist: a behavioural UART loopback (with optional
// corruption, dropped ready and forced busy) plus a run-level result model.
module tb_uart_loopback_bist;

  localparam int DW  = 8;
  localparam int NW  = 4;
  localparam int TMO = 100;
  localparam int CW  = $clog2(NW + 1);
  localparam int LAT = 12;

  logic          clk_50m = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pattern_sel = 1'b0;
  logic          tx_busy = 1'b0;
  logic          rx_ready = 1'b0;
  logic [DW-1:0] rx_data = 8'h00;
  logic [DW-1:0] tx_data, first_exp, first_got;
  logic          tx_wr_en, rx_ready_clr, busy, done, pass, timeout;
  logic [CW-1:0] err_count, words_done;

  uart_loopback_bist #(
    .DATA_W(DW), .NUM_WORDS(NW), .TIMEOUT_CYC(TMO),
    .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01), .STOP_ON_FAIL(1'b1)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .start(start), .pattern_sel(pattern_sel),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
    .rx_ready(rx_ready), .rx_ready_clr(rx_ready_clr), .rx_data(rx_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .words_done(words_done),
    .first_exp(first_exp), .first_got(first_got)
  );

  always #10 clk_50m = ~clk_50m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run configuration and expected run results
  int         cfg_corrupt_idx = -1;
  logic [7:0] cfg_corrupt_val = 8'h00;
  int         cfg_drop_idx = -1;
  logic       force_busy = 1'b0;
  logic [7:0] exp_tx [0:NW-1];
  int exp_err, exp_words, exp_fe, exp_fg, exp_tmo, exp_pass, exp_sent;

  // Result model: walk the words of a run and apply the stop/timeout rules.
  task automatic compute_expect(input logic sel);
    logic [7:0] p;
    logic [7:0] got;
    p = sel ? 8'h01 : 8'h00;
    for (int i = 0; i < NW; i++) begin
      exp_tx[i] = p;
      if (sel) p = p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
      else     p = p + 8'h01;
    end
    exp_err = 0; exp_words = 0; exp_fe = 0; exp_fg = 0; exp_tmo = 0; exp_sent = 0;
    for (int i = 0; i < NW; i++) begin
      exp_sent++;
      if (i == cfg_drop_idx) begin
        exp_tmo = 1;
        break;
      end
      got = (i == cfg_corrupt_idx) ? cfg_corrupt_val : exp_tx[i];
      exp_words++;
      if (got != exp_tx[i]) begin
        if (exp_err == 0) begin
          exp_fe = int'(exp_tx[i]);
          exp_fg = int'(got);
        end
        exp_err++;
        break;
      end
    end
    exp_pass = (exp_err == 0 && exp_tmo == 0) ? 1 : 0;
  endtask

  // Loopback UART: busy for LAT cycles after wr_en, then ready with the word.
  int         word_idx = 0;
  int         frame_cnt = 0;
  int         frame_idx = 0;
  logic [7:0] frame_data = 8'h00;
  initial begin : uart_model
    forever begin
      @(negedge clk_50m);
      if (rst) begin
        frame_cnt = 0;
        rx_ready = 1'b0;
      end else begin
        if (rx_ready_clr) rx_ready = 1'b0;
        if (frame_cnt > 0) begin
          frame_cnt--;
          if (frame_cnt == 0 && frame_idx != cfg_drop_idx) begin
            rx_ready = 1'b1;
            rx_data  = (frame_idx == cfg_corrupt_idx) ? cfg_corrupt_val : frame_data;
          end
        end else if (tx_wr_en) begin
          frame_cnt  = LAT;
          frame_data = tx_data;
          frame_idx  = word_idx;
          word_idx++;
        end
      end
      tx_busy = force_busy || (frame_cnt > 0);
    end
  end

  // Compare process: per-cycle invariants, per-word tx data, run results at done.
  int         wr_cnt = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  logic       prev_wr = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] txlog [0:NW-1];
  initial begin : compare
    forever begin
      @(negedge clk_50m);
      cyc++;
      if (!rst) begin
        chk("wr_clr_exclusive", int'(tx_wr_en & rx_ready_clr), 0);
        chk("busy_done_exclusive", int'(busy & done), 0);
        if (tx_wr_en) begin
          chk("wr_pulse_width", int'(prev_wr), 0);
          chk("wr_count_in_range", (wr_cnt < NW) ? 1 : 0, 1);
          if (wr_cnt < NW) begin
            chk("tx_word", int'(tx_data), int'(exp_tx[wr_cnt]));
            txlog[wr_cnt] = tx_data;
          end
          wr_cnt++;
          last_wr_cyc = cyc;
        end
        if (done && !prev_done) begin
          chk("res_pass", int'(pass), exp_pass);
          chk("res_err_count", int'(err_count), exp_err);
          chk("res_words_done", int'(words_done), exp_words);
          chk("res_first_exp", int'(first_exp), exp_fe);
          chk("res_first_got", int'(first_got), exp_fg);
          chk("res_timeout", int'(timeout), exp_tmo);
          chk("res_words_sent", wr_cnt, exp_sent);
          if (exp_tmo != 0) begin
            chk("timeout_latency_window",
                (cyc - last_wr_cyc >= TMO - 2 && cyc - last_wr_cyc <= TMO + 2) ? 1 : 0, 1);
          end
        end
      end
      prev_wr   = tx_wr_en;
      prev_done = done;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_tx_wr_en"}, int'(tx_wr_en), 0);
    chk({tag, "_rx_ready_clr"}, int'(rx_ready_clr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_words_done"}, int'(words_done), 0);
    chk({tag, "_first_exp"}, int'(first_exp), 0);
    chk({tag, "_first_got"}, int'(first_got), 0);
  endtask

  task automatic launch(input logic sel, input int cidx, input logic [7:0] cval,
                        input int didx, input bit hold_busy);
    cfg_corrupt_idx = cidx;
    cfg_corrupt_val = cval;
    cfg_drop_idx    = didx;
    compute_expect(sel);
    word_idx = 0;
    wr_cnt   = 0;
    if (hold_busy) force_busy = 1'b1;
    @(negedge clk_50m);
    pattern_sel = sel;
    start = 1'b1;
    @(negedge clk_50m);
    start = 1'b0;
  endtask

  task automatic run_test(input logic sel, input int cidx, input logic [7:0] cval,
                          input int didx, input bit hold_busy, input bit mid_start);
    launch(sel, cidx, cval, didx, hold_busy);
    if (hold_busy) begin
      repeat (20) @(negedge clk_50m);
      chk("busy_gate_no_wr", wr_cnt, 0);
      chk("busy_gate_running", int'(busy), 1);
      force_busy = 1'b0;
    end
    if (mid_start) begin
      for (int i = 0; i < 500 && wr_cnt < 2; i++) @(negedge clk_50m);
      chk("mid_start_reached_word2", (wr_cnt >= 2) ? 1 : 0, 1);
      pattern_sel = 1'b1;
      start = 1'b1;
      @(negedge clk_50m);
      start = 1'b0;
      chk("mid_start_still_busy", int'(busy), 1);
    end
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk_50m);
    chk("done_within_budget", int'(done), 1);
    @(negedge clk_50m);
  endtask

  initial begin : main
    repeat (3) @(negedge clk_50m);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk_50m);

    // Incrementing pattern, ideal loopback
    run_test(1'b0, -1, 8'h00, -1, 1'b0, 1'b0);
    chk("t1_tx2_literal", int'(txlog[2]), 8'h02);
    chk("t1_tx3_literal", int'(txlog[3]), 8'h03);
    chk("t1_pass_literal", int'(pass), 1);
    chk("t1_words_literal", int'(words_done), 4);

    // Word 1 corrupted to 03, stop at first fail
    run_test(1'b0, 1, 8'h03, -1, 1'b0, 1'b0);
    chk("t2_first_exp_literal", int'(first_exp), 8'h01);
    chk("t2_first_got_literal", int'(first_got), 8'h03);
    chk("t2_err_literal", int'(err_count), 1);
    chk("t2_words_literal", int'(words_done), 2);
    chk("t2_pass_literal", int'(pass), 0);

    // Receive ready never rises
    run_test(1'b0, -1, 8'h00, 0, 1'b0, 1'b0);
    chk("t3_timeout_literal", int'(timeout), 1);
    chk("t3_words_literal", int'(words_done), 0);
    chk("t3_pass_literal", int'(pass), 0);

    // LFSR pattern
    run_test(1'b1, -1, 8'h00, -1, 1'b0, 1'b0);
    chk("t4_tx0_literal", int'(txlog[0]), 8'h01);
    chk("t4_tx1_literal", int'(txlog[1]), 8'hB8);
    chk("t4_tx2_literal", int'(txlog[2]), 8'h5C);
    chk("t4_tx3_literal", int'(txlog[3]), 8'h2E);
    chk("t4_pass_literal", int'(pass), 1);
    chk("t4_timeout_literal", int'(timeout), 0);

    // tx_busy held after start, plus a start pulse in mid-run
    run_test(1'b0, -1, 8'h00, -1, 1'b1, 1'b1);
    chk("t5_pass_literal", int'(pass), 1);
    chk("t5_words_sent_literal", wr_cnt, 4);

    // Reset while waiting for receive, then a fresh run
    launch(1'b0, -1, 8'h00, -1, 1'b0);
    for (int i = 0; i < 200 && wr_cnt < 1; i++) @(negedge clk_50m);
    chk("t6_reached_wait", wr_cnt, 1);
    repeat (2) @(negedge clk_50m);
    chk("t6_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk_50m);
    chk_all_zero("t6_after_rst");
    rst = 1'b0;
    @(negedge clk_50m);
    run_test(1'b0, -1, 8'h00, -1, 1'b0, 1'b0);
    chk("t6_tx0_literal", int'(txlog[0]), 8'h00);
    chk("t6_pass_literal", int'(pass), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
